// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus initiator: FSM states, target
// geometry and the default acknowledge timeout.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } reg_bus_state_e;

  localparam int REG_TGT_W           = 2;
  localparam int REG_NUM_TGT         = 4;
  localparam int REG_DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/reg_bus_initiator.sv
// Register-bus initiator: takes one read/write command at a time, runs a
// setup/select/acknowledge bus transaction and returns a response with a timeout flag.
module reg_bus_initiator
  import reg_bus_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = REG_DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [REG_TGT_W-1:0]   cmd_tgt,
  input  logic [AW-1:0]          cmd_addr,
  input  logic [DW-1:0]          cmd_wdata,
  output logic                   reg_sel,
  output logic                   reg_wr,
  output logic [REG_TGT_W-1:0]   reg_tgt,
  output logic [AW-1:0]          reg_addr,
  output logic [DW-1:0]          reg_wdata,
  input  logic [REG_NUM_TGT-1:0] pci_ack,
  input  logic [DW-1:0]          reg_rdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_err,
  output logic [DW-1:0]          rsp_rdata
);

  localparam int            CW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

  reg_bus_state_e state;
  reg_bus_state_e state_next;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_next;
  logic [CW-1:0]  cnt_inc;
  logic           ack_hit;
  logic           accept;
  logic           rsp_err_next;
  logic [DW-1:0]  rsp_rdata_next;

  // Only the selected target's acknowledge matters; the rest are ignored.
  assign ack_hit = pci_ack[reg_tgt];
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign accept  = cmd_valid && cmd_ready;

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    cmd_ready      = 1'b0;
    rsp_err_next   = rsp_err;
    rsp_rdata_next = rsp_rdata;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        cnt_next   = '0;
        state_next = ACCESS;
      end
      ACCESS: begin
        // An acknowledge on the final allowed cycle still beats the timeout.
        if (ack_hit) begin
          rsp_err_next   = 1'b0;
          rsp_rdata_next = reg_wr ? '0 : reg_rdata;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc >= TIMEOUT_CNT) begin
            rsp_err_next   = 1'b1;
            rsp_rdata_next = '0;
            state_next     = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      reg_sel   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      reg_sel   <= (state_next == ACCESS);
      rsp_valid <= (state_next == RESP);
      rsp_err   <= rsp_err_next;
      rsp_rdata <= rsp_rdata_next;
    end
  end

  // Bus fields are captured once at acceptance and held until the next command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_wr    <= 1'b0;
      reg_tgt   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else if (accept) begin
      reg_wr    <= cmd_wr;
      reg_tgt   <= cmd_tgt;
      reg_addr  <= cmd_addr;
      reg_wdata <= cmd_wdata;
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Self-checking bench for reg_bus_initiator: directed vector table, reset
// abort sequence and randomized transactions against a transaction-level model.
module tb_reg_bus_initiator;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [1:0]    cmd_tgt;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          reg_sel;
  logic          reg_wr;
  logic [1:0]    reg_tgt;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [3:0]    pci_ack;
  logic [DW-1:0] reg_rdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic          wr;
    logic [1:0]    tgt;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_cycle;
    logic [DW-1:0] rdata;
    int            rsp_delay;
    logic          hold_valid;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_sel;
  } vec_t;

  reg_bus_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_tgt(cmd_tgt), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_tgt(reg_tgt),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .pci_ack(pci_ack), .reg_rdata(reg_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: an acknowledge within the window ends the
  // select phase at that cycle, otherwise the window runs out with an error.
  task automatic model(inout vec_t v);
    if (v.ack_cycle >= 1 && v.ack_cycle <= TO) begin
      v.exp_err   = 1'b0;
      v.exp_rdata = v.wr ? '0 : v.rdata;
      v.exp_sel   = v.ack_cycle;
    end else begin
      v.exp_err   = 1'b1;
      v.exp_rdata = '0;
      v.exp_sel   = TO;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
    check_output({tag, ".reg_sel"},   64'(reg_sel),   64'd0);
    check_output({tag, ".reg_wr"},    64'(reg_wr),    64'd0);
    check_output({tag, ".reg_tgt"},   64'(reg_tgt),   64'd0);
    check_output({tag, ".reg_addr"},  64'(reg_addr),  64'd0);
    check_output({tag, ".reg_wdata"}, 64'(reg_wdata), 64'd0);
    check_output({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_output({tag, ".rsp_err"},   64'(rsp_err),   64'd0);
    check_output({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'd0);
  endtask

  // Runs one transaction; k counts cycles after the acceptance edge
  // (k=1 setup, k=2..1+sel select, then response until handshake).
  task automatic apply_stimulus(input vec_t v, input string tag);
    int         total;
    logic       in_access;
    logic       exp_valid;
    logic [3:0] ack;
    cmd_wr    = v.wr;
    cmd_tgt   = v.tgt;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_valid = 1'b1;
    check_output({tag, ".ready_idle"}, 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    if (v.hold_valid) begin
      cmd_wr    = ~v.wr;
      cmd_tgt   = v.tgt + 2'd1;
      cmd_addr  = ~v.addr;
      cmd_wdata = ~v.wdata;
    end else begin
      cmd_valid = 1'b0;
    end
    total = 2 + v.exp_sel + v.rsp_delay;
    for (int k = 1; k <= total; k++) begin
      in_access = (k >= 2) && (k <= 1 + v.exp_sel);
      exp_valid = (k >= 2 + v.exp_sel);
      check_output($sformatf("%s.sel@%0d", tag, k),   64'(reg_sel),   64'(in_access));
      check_output($sformatf("%s.valid@%0d", tag, k), 64'(rsp_valid), 64'(exp_valid));
      check_output($sformatf("%s.ready@%0d", tag, k), 64'(cmd_ready), 64'd0);
      check_output($sformatf("%s.bus@%0d", tag, k),
                   {21'd0, reg_wr, reg_tgt, reg_addr, reg_wdata},
                   {21'd0, v.wr, v.tgt, v.addr, v.wdata});
      if (exp_valid) begin
        check_output($sformatf("%s.err@%0d", tag, k),   64'(rsp_err),   64'(v.exp_err));
        check_output($sformatf("%s.rdata@%0d", tag, k), 64'(rsp_rdata), 64'(v.exp_rdata));
      end
      ack = 4'($urandom);
      if (in_access) ack[v.tgt] = (k - 1 == v.ack_cycle);
      pci_ack   = ack;
      reg_rdata = (in_access && (k - 1 == v.ack_cycle)) ? v.rdata : DW'($urandom);
      rsp_ready = exp_valid ? (k == total) : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    pci_ack   = '0;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check_output({tag, ".valid_done"}, 64'(rsp_valid), 64'd0);
    check_output({tag, ".ready_done"}, 64'(cmd_ready), 64'd1);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    tbl[0] = '{1'b1, 2'd2, 8'h10, 32'hDEADBEEF, 1,  32'h0,        0, 1'b0, 1'b0, 32'h0,        1};
    tbl[1] = '{1'b0, 2'd1, 8'h24, 32'h0,        3,  32'h12345678, 0, 1'b0, 1'b0, 32'h12345678, 3};
    tbl[2] = '{1'b0, 2'd0, 8'h33, 32'h0,        0,  32'h0,        1, 1'b0, 1'b1, 32'h0,        16};
    tbl[3] = '{1'b0, 2'd3, 8'hF0, 32'h0,        16, 32'hCAFEF00D, 0, 1'b0, 1'b0, 32'hCAFEF00D, 16};
    tbl[4] = '{1'b1, 2'd1, 8'h08, 32'h5555AAAA, 2,  32'h0,        5, 1'b1, 1'b0, 32'h0,        2};
    tbl[5] = '{1'b0, 2'd2, 8'h7F, 32'h0,        17, 32'hFFFFFFFF, 2, 1'b1, 1'b1, 32'h0,        16};
    tbl[6] = '{1'b1, 2'd3, 8'hFF, 32'h01020304, 0,  32'h0,        0, 1'b0, 1'b1, 32'h0,        16};

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_tgt   = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    pci_ack   = '0;
    reg_rdata = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while selecting: outputs clear at once and no response follows.
    cmd_wr    = 1'b1;
    cmd_tgt   = 2'd1;
    cmd_addr  = 8'h5A;
    cmd_wdata = 32'hA5A5A5A5;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_output("rst.sel_before", 64'(reg_sel), 64'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset_values("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b1;
    pci_ack = 4'hF;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check_output($sformatf("rst.no_rsp@%0d", k), 64'(rsp_valid), 64'd0);
    end
    pci_ack = '0;
    apply_stimulus(tbl[1], "after_rst");

    for (int i = 0; i < 25; i++) begin
      rv.wr         = 1'($urandom_range(0, 1));
      rv.tgt        = 2'($urandom);
      rv.addr       = AW'($urandom);
      rv.wdata      = DW'($urandom);
      rv.ack_cycle  = $urandom_range(0, TO + 2);
      rv.rdata      = DW'($urandom);
      rv.rsp_delay  = $urandom_range(0, 3);
      rv.hold_valid = 1'($urandom_range(0, 1));
      model(rv);
      apply_stimulus(rv, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
